// File: rtl/dot_product_stream_engine.sv
// Folded signed dot-product engine: LANES/FOLD multipliers, registered adder tree, per-job accumulation.
// Define DOT_PRODUCT_SAT_EN for a saturating accumulator with a sticky sat_flag; otherwise it wraps.
module dot_product_stream_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 8,
  parameter int unsigned FOLD   = 2,
  parameter int unsigned ACC_W  = 2*DATA_W+8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W*LANES-1:0] a_vec,
  input  logic [DATA_W*LANES-1:0] b_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        result,
  output logic                    busy,
  output logic                    sat_flag
);

  localparam int unsigned VEC_W   = DATA_W * LANES;
  localparam int unsigned MULTS   = LANES / FOLD;
  localparam int unsigned SLICE_W = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int unsigned PROD_W  = 2 * DATA_W;
  localparam int unsigned TREE_W  = PROD_W + $clog2(MULTS) + 1;
  // Slice sums keep full precision even when ACC_W is narrower than one slice's sum.
  localparam int unsigned SUM_W   = (ACC_W > TREE_W) ? ACC_W : TREE_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                   slice_active_q, slice_active_d;
  logic [SLICE_W-1:0]     slice_cnt_q, slice_cnt_d;
  logic                   in_ready_d, out_valid_d, busy_d;
  logic [ACC_W-1:0]       result_d;
  logic                   accept_c, job_start_c, pipe_empty_c;

  logic [VEC_W-1:0]       a_reg, b_reg;
  logic signed [DATA_W-1:0] op_a [MULTS];
  logic signed [DATA_W-1:0] op_b [MULTS];
  logic signed [PROD_W-1:0] prod_q [MULTS];
  logic                   prod_valid_q;
  logic signed [SUM_W-1:0] tree_sum_c, sum_q;
  logic                   sum_valid_q;
  logic signed [ACC_W-1:0] acc_q, acc_next_c;

  assign accept_c     = in_valid && in_ready;
  assign pipe_empty_c = !slice_active_q && !prod_valid_q && !sum_valid_q;

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      len_q          <= '0;
      beat_cnt_q     <= '0;
      slice_active_q <= 1'b0;
      slice_cnt_q    <= '0;
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      result         <= '0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      beat_cnt_q     <= beat_cnt_d;
      slice_active_q <= slice_active_d;
      slice_cnt_q    <= slice_cnt_d;
      in_ready       <= in_ready_d;
      out_valid      <= out_valid_d;
      result         <= result_d;
      busy           <= busy_d;
    end
  end

  // Next-state, counters and registered-output next values
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    beat_cnt_d     = beat_cnt_q;
    slice_active_d = slice_active_q;
    slice_cnt_d    = slice_cnt_q;
    out_valid_d    = out_valid;
    result_d       = result;
    job_start_c    = 1'b0;

    if (accept_c) begin
      slice_active_d = 1'b1;
      slice_cnt_d    = '0;
      beat_cnt_d     = beat_cnt_q + LEN_W'(1);
    end else if (slice_active_q) begin
      if (slice_cnt_q == SLICE_W'(FOLD-1)) begin
        slice_active_d = 1'b0;
        slice_cnt_d    = '0;
      end else begin
        slice_cnt_d = slice_cnt_q + SLICE_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          job_start_c = 1'b1;
          len_d       = len;
          beat_cnt_d  = '0;
          if (len == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept_c && (beat_cnt_d == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty_c) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = acc_q;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    // Ready re-opens during the last slice so one beat can enter every FOLD cycles.
    in_ready_d = (state_d == RUN) && (beat_cnt_d < len_d) &&
                 (!slice_active_d || (slice_cnt_d == SLICE_W'(FOLD-1)));
  end

  // Beat capture
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept_c) begin
      a_reg <= a_vec;
      b_reg <= b_vec;
    end
  end

  // Slice operand select
  always_comb begin
    for (int m = 0; m < MULTS; m++) begin
      op_a[m] = a_reg[m*DATA_W +: DATA_W];
      op_b[m] = b_reg[m*DATA_W +: DATA_W];
      for (int s = 1; s < FOLD; s++) begin
        if (slice_cnt_q == SLICE_W'(s)) begin
          op_a[m] = a_reg[(s*MULTS+m)*DATA_W +: DATA_W];
          op_b[m] = b_reg[(s*MULTS+m)*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Multiplier stage
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_valid_q <= 1'b0;
      for (int m = 0; m < MULTS; m++) prod_q[m] <= '0;
    end else begin
      prod_valid_q <= slice_active_q;
      if (slice_active_q) begin
        for (int m = 0; m < MULTS; m++) prod_q[m] <= PROD_W'(op_a[m]) * PROD_W'(op_b[m]);
      end
    end
  end

  // Reduction of one slice's products
  always_comb begin
    tree_sum_c = '0;
    for (int m = 0; m < MULTS; m++) tree_sum_c = tree_sum_c + SUM_W'(prod_q[m]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      sum_valid_q <= prod_valid_q;
      if (prod_valid_q) sum_q <= tree_sum_c;
    end
  end

`ifdef DOT_PRODUCT_SAT_EN
  localparam int unsigned EXT_W = SUM_W + 1;
  logic signed [EXT_W-1:0] acc_ext_c;
  logic                    clamp_c;

  // Saturating add: any disagreement in the bits above the ACC_W sign bit is an overflow.
  always_comb begin
    acc_ext_c  = EXT_W'(acc_q) + EXT_W'(sum_q);
    clamp_c    = (acc_ext_c[EXT_W-1:ACC_W-1] != {(EXT_W-ACC_W+1){acc_ext_c[EXT_W-1]}});
    acc_next_c = acc_ext_c[ACC_W-1:0];
    if (clamp_c) begin
      if (acc_ext_c[EXT_W-1]) acc_next_c = {1'b1, {(ACC_W-1){1'b0}}};
      else                    acc_next_c = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                         sat_flag <= 1'b0;
    else if (job_start_c)              sat_flag <= 1'b0;
    else if (sum_valid_q && clamp_c)   sat_flag <= 1'b1;
  end
`else
  always_comb begin
    acc_next_c = acc_q + ACC_W'(sum_q);
  end

  assign sat_flag = 1'b0;
`endif

  // Accumulator
  always_ff @(posedge clk) begin
    if (reset)            acc_q <= '0;
    else if (job_start_c) acc_q <= '0;
    else if (sum_valid_q) acc_q <= acc_next_c;
  end

endmodule

// File: tb/tb_dot_product_stream_engine.sv
// Self-checking bench for dot_product_stream_engine: directed scenarios plus random jobs against a lane-sum model.
// A second narrow instance (DATA_W=8, ACC_W=16) checks wrap or saturation depending on DOT_PRODUCT_SAT_EN.
module tb_dot_product_stream_engine;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 8;
  localparam int unsigned FOLD   = 2;
  localparam int unsigned ACC_W  = 2*DATA_W+8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned VEC_W  = DATA_W*LANES;
  localparam int unsigned S_DW   = 8;
  localparam int unsigned S_ACC  = 16;
  localparam int unsigned S_VEC  = S_DW*LANES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, start, in_valid, in_ready, out_valid, out_ready, busy, sat_flag;
  logic [LEN_W-1:0] len;
  logic [VEC_W-1:0] a_vec, b_vec;
  logic [ACC_W-1:0] result;

  logic             s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy, s_sat_flag;
  logic [LEN_W-1:0] s_len;
  logic [S_VEC-1:0] s_a, s_b;
  logic [S_ACC-1:0] s_result;

  int n_checks = 0;
  int n_fail   = 0;

  dot_product_stream_engine #(.DATA_W(DATA_W), .LANES(LANES), .FOLD(FOLD), .ACC_W(ACC_W), .LEN_W(LEN_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy), .sat_flag(sat_flag));

  dot_product_stream_engine #(.DATA_W(S_DW), .LANES(LANES), .FOLD(FOLD), .ACC_W(S_ACC), .LEN_W(LEN_W)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .len(s_len), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a_vec(s_a), .b_vec(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
    .busy(s_busy), .sat_flag(s_sat_flag));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  function automatic logic [S_VEC-1:0] rand_small();
    logic [S_VEC-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*S_DW +: S_DW] = S_DW'($urandom);
    return v;
  endfunction

  // Reference: plain signed sum over all lanes of one beat
  function automatic logic signed [127:0] beat_dot(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    logic signed [127:0]      s;
    logic signed [DATA_W-1:0] x, y;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      x = a[i*DATA_W +: DATA_W];
      y = b[i*DATA_W +: DATA_W];
      s = s + x * y;
    end
    return s;
  endfunction

  task automatic run_job(input int n, input bit rand_valid, input bit fixed,
                         input logic [VEC_W-1:0] fa, input logic [VEC_W-1:0] fb,
                         input bit use_want, input logic signed [127:0] want, input string tag);
    logic signed [127:0] exp;
    int got, budget, k;
    bit acc_now;
    exp = 0; got = 0; budget = 0;
    len = LEN_W'(n); start = 1'b1; tick(); start = 1'b0; len = '0;
    chk({tag, " busy_after_start"}, 128'(busy), 128'(1));
    chk({tag, " in_ready_after_start"}, 128'(in_ready), 128'(n > 0));
    while (got < n && budget < 1000) begin
      a_vec = fixed ? fa : rand_vec();
      b_vec = fixed ? fb : rand_vec();
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      acc_now = in_valid && in_ready;
      tick(); budget++;
      if (acc_now) begin
        exp = exp + beat_dot(a_vec, b_vec);
        got++;
        chk({tag, " in_ready_low_after_accept"}, 128'(in_ready), 128'(0));
      end
    end
    in_valid = 1'b0;
    chk({tag, " beats_accepted"}, 128'(got), 128'(n));
    if (!rand_valid && n > 0) chk({tag, " held_valid_cycles"}, 128'(budget), 128'(2*n-1));
    k = 0;
    while (!out_valid && k < 40) begin tick(); k++; end
    chk({tag, " latency"}, 128'(k), 128'((n == 0) ? 0 : FOLD+3));
    chk({tag, " out_valid"}, 128'(out_valid), 128'(1));
    chk({tag, " result"}, 128'(result), 128'(exp[ACC_W-1:0]));
    if (use_want) chk({tag, " result_const"}, 128'(result), 128'(want[ACC_W-1:0]));
    chk({tag, " sat_flag"}, 128'(sat_flag), 128'(0));
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3); len = LEN_W'(5);
      tick();
    end
    start = 1'b0;
    chk({tag, " held_valid"}, 128'(out_valid), 128'(1));
    chk({tag, " held_result"}, 128'(result), 128'(exp[ACC_W-1:0]));
    chk({tag, " held_busy"}, 128'(busy), 128'(1));
    out_ready = 1'b1; start = 1'b1; tick();
    out_ready = 1'b0; start = 1'b0;
    chk({tag, " valid_dropped"}, 128'(out_valid), 128'(0));
    tick();
    chk({tag, " idle_after_handshake"}, 128'(busy), 128'(0));
  endtask

  // Narrow instance: model accumulates slice by slice, clamping when saturation is built in
  task automatic run_small(input int n, input bit fixed, input logic [S_VEC-1:0] fa, input logic [S_VEC-1:0] fb,
                           input bit use_want, input logic [S_ACC-1:0] want, input bit want_sat, input string tag);
    logic signed [127:0] macc, ssum, smax, smin;
    logic signed [S_DW-1:0] x, y;
    bit sf, acc_now;
    int got, budget, k;
    smax = (128'sd1 <<< (S_ACC-1)) - 1;
    smin = -(128'sd1 <<< (S_ACC-1));
    macc = 0; sf = 0; got = 0; budget = 0;
    s_len = LEN_W'(n); s_start = 1'b1; tick(); s_start = 1'b0;
    chk({tag, " sat_cleared_on_start"}, 128'(s_sat_flag), 128'(0));
    while (got < n && budget < 200) begin
      s_a = fixed ? fa : rand_small();
      s_b = fixed ? fb : rand_small();
      s_in_valid = 1'b1;
      acc_now = s_in_valid && s_in_ready;
      tick(); budget++;
      if (acc_now) begin
        got++;
        for (int sl = 0; sl < FOLD; sl++) begin
          ssum = 0;
          for (int j = 0; j < LANES/FOLD; j++) begin
            x = s_a[(sl*(LANES/FOLD)+j)*S_DW +: S_DW];
            y = s_b[(sl*(LANES/FOLD)+j)*S_DW +: S_DW];
            ssum = ssum + x * y;
          end
          macc = macc + ssum;
`ifdef DOT_PRODUCT_SAT_EN
          if (macc > smax) begin macc = smax; sf = 1'b1; end
          else if (macc < smin) begin macc = smin; sf = 1'b1; end
`endif
        end
      end
    end
    s_in_valid = 1'b0;
    chk({tag, " beats_accepted"}, 128'(got), 128'(n));
    k = 0;
    while (!s_out_valid && k < 40) begin tick(); k++; end
    chk({tag, " out_valid"}, 128'(s_out_valid), 128'(1));
    chk({tag, " result"}, 128'(s_result), 128'(macc[S_ACC-1:0]));
    chk({tag, " sat_flag"}, 128'(s_sat_flag), 128'(sf));
    if (use_want) begin
      chk({tag, " result_const"}, 128'(s_result), 128'(want));
      chk({tag, " sat_const"}, 128'(s_sat_flag), 128'(want_sat));
    end
    s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
    chk({tag, " valid_dropped"}, 128'(s_out_valid), 128'(0));
  endtask

  initial begin
    logic [VEC_W-1:0] va, vb;
    logic [S_VEC-1:0] sa;
    logic [S_ACC-1:0] s_want;
    bit s_want_sat;
    int seen;

    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0; a_vec = '0; b_vec = '0;
    s_start = 1'b0; s_len = '0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0;
    repeat (3) tick();
    chk("reset in_ready", 128'(in_ready), 128'(0));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset result", 128'(result), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset sat_flag", 128'(sat_flag), 128'(0));
    chk("reset small busy", 128'(s_busy), 128'(0));
    reset = 1'b0;
    tick();

    // Lanes 1..8 against all ones
    for (int i = 0; i < LANES; i++) begin
      va[i*DATA_W +: DATA_W] = DATA_W'(i+1);
      vb[i*DATA_W +: DATA_W] = DATA_W'(1);
    end
    run_job(1, 1'b0, 1'b1, va, vb, 1'b1, 128'sd36, "s1");

    // Lane i = i against all twos, three beats with valid held
    for (int i = 0; i < LANES; i++) begin
      va[i*DATA_W +: DATA_W] = DATA_W'(i);
      vb[i*DATA_W +: DATA_W] = DATA_W'(2);
    end
    run_job(3, 1'b0, 1'b1, va, vb, 1'b1, 128'sd168, "s2");

    // All -3 against all 5
    for (int i = 0; i < LANES; i++) begin
      va[i*DATA_W +: DATA_W] = -DATA_W'(3);
      vb[i*DATA_W +: DATA_W] = DATA_W'(5);
    end
    run_job(2, 1'b0, 1'b1, va, vb, 1'b1, -128'sd240, "s3");

    run_job(0, 1'b0, 1'b0, '0, '0, 1'b1, 128'sd0, "s4_len0");

    // Reset two cycles into a len=4 job
    len = LEN_W'(4); start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; a_vec = rand_vec(); b_vec = rand_vec();
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0; in_valid = 1'b0;
    chk("s5 busy", 128'(busy), 128'(0));
    chk("s5 in_ready", 128'(in_ready), 128'(0));
    chk("s5 out_valid", 128'(out_valid), 128'(0));
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("s5 no_out_pulse", 128'(seen), 128'(0));
    run_job(1, 1'b0, 1'b0, '0, '0, 1'b0, 128'sd0, "s5_fresh");

    for (int j = 0; j < 6; j++) run_job(int'($urandom_range(1, 6)), 1'b1, 1'b0, '0, '0, 1'b0, 128'sd0, "rand");

    // Narrow instance: all lanes 127 overflows a 16-bit accumulator
    for (int i = 0; i < LANES; i++) sa[i*S_DW +: S_DW] = S_DW'(127);
`ifdef DOT_PRODUCT_SAT_EN
    s_want = 16'h7FFF; s_want_sat = 1'b1;
`else
    s_want = 16'hF808; s_want_sat = 1'b0;
`endif
    run_small(1, 1'b1, sa, sa, 1'b1, s_want, s_want_sat, "s6");
    run_small(3, 1'b0, '0, '0, 1'b0, '0, 1'b0, "s6_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
